// File: rtl/gf_inverter_scheduler.sv
// gf_inverter_scheduler: round-robin time-sharing of one fixed-latency GF(2^M) inverter among N requesters
module gf_inverter_scheduler #(
  parameter int M = 8,
  parameter int N = 4,
  parameter int LATENCY = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*M-1:0]   req_data,
  output logic [N-1:0]     ack,
  output logic             inv_start,
  output logic [M-1:0]     inv_in,
  input  logic [M-1:0]     inv_out,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [M-1:0]     res_data,
  output logic             res_zero,
  output logic             busy
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] rr_ptr, win;
  logic           found, cool;
  logic [M-1:0]   ops [N];
  logic [M-1:0]   op;
  for (genvar g = 0; g < N; g++) begin : g_ops
    assign ops[g] = req_data[g*M +: M];
  end
  assign op = ops[win];
  // Round-robin pick: scan downward so the nearest requester after rr_ptr is written last
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[IDW'((int'(rr_ptr) + i) % N)]) begin
        found = 1'b1;
        win = IDW'((int'(rr_ptr) + i) % N);
      end
    end
  end
  // Controller: grant in IDLE (after one quiet cycle following a result), run or bypass, then strobe the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= IDW'(N - 1);
      cool <= 1'b0;
      ack <= '0;
      inv_start <= 1'b0;
      inv_in <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_data <= '0;
      res_zero <= 1'b0;
      busy <= 1'b0;
    end else begin
      ack <= '0;
      inv_start <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          cool <= 1'b0;
          if (found && !cool) begin
            rr_ptr <= win;
            inv_in <= op;
            res_id <= win;
            ack <= {{(N-1){1'b0}}, 1'b1} << win;
            inv_start <= |op;
            res_zero <= 1'b0;
            cnt <= CW'(LATENCY - 1);
            busy <= 1'b1;
            state <= |op ? RUN : ZERO;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_data <= inv_out;
            res_valid <= 1'b1;
            state <= DONE;
          end
        end
        ZERO: begin
          res_data <= '0;
          res_zero <= 1'b1;
          res_valid <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy <= 1'b0;
          cool <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gf_inverter_scheduler.sv
// tb_gf_inverter_scheduler: directed checks of the shared-inverter scheduler with a behavioural GF(2^8) inverter
module tb_gf_inverter_scheduler;
  logic clk = 0, reset = 1;
  logic [3:0] req0 = '0, ack0, req1 = '0, ack1;
  logic [31:0] data0 = '0, data1 = '0;
  logic inv_start0, res_valid0, res_zero0, busy0, inv_start1, res_valid1, res_zero1, busy1;
  logic [7:0] inv_in0, inv_out0, res_data0, inv_in1, inv_out1, res_data1;
  logic [1:0] res_id0, res_id1;
  int errors = 0, checks = 0, cyc = 0, age = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b >>= 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    for (int i = 1; i < 256; i++) if (gmul(a, 8'(i)) == 8'h01) return 8'(i);
    return 8'h00;
  endfunction
  // LATENCY=8 inverter: result valid in the 8th cycle counting the start cycle, garbage otherwise
  always @(posedge clk) age <= inv_start0 ? 1 : age + 1;
  assign inv_out0 = (!inv_start0 && age == 7) ? gf_inv(inv_in0) : 8'hEE;
  assign inv_out1 = inv_start1 ? gf_inv(inv_in1) : 8'hEE;
  gf_inverter_scheduler #(.M(8), .N(4), .LATENCY(8)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_data(data0), .ack(ack0), .inv_start(inv_start0),
    .inv_in(inv_in0), .inv_out(inv_out0), .res_valid(res_valid0), .res_id(res_id0),
    .res_data(res_data0), .res_zero(res_zero0), .busy(busy0));
  gf_inverter_scheduler #(.M(8), .N(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .req_data(data1), .ack(ack1), .inv_start(inv_start1),
    .inv_in(inv_in1), .inv_out(inv_out1), .res_valid(res_valid1), .res_id(res_id1),
    .res_data(res_data1), .res_zero(res_zero1), .busy(busy1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack(input string tag, input logic [3:0] exp);
    int n = 0;
    while (ack0 == 4'b0 && n < 40) begin tick(); n++; end
    chk(tag, ack0, exp);
  endtask
  task automatic wait_valid(input string tag, input logic [1:0] id, input logic [7:0] d);
    int n = 0;
    while (!res_valid0 && n < 40) begin tick(); n++; end
    chk({tag, "_valid"}, res_valid0, 1);
    chk({tag, "_id"}, res_id0, id);
    chk({tag, "_data"}, res_data0, d);
  endtask
  initial begin
    int last = 0, seen = 0;
    logic [1:0] e;
    tick(); tick();
    chk("rst_ack", ack0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_valid", res_valid0, 0);
    chk("rst_inv_in", inv_in0, 0);
    reset = 0;
    tick();
    // single nonzero operand, requester 0
    data0 = 32'h0000_0053; req0 = 4'b0001;
    tick();
    chk("t1_ack", ack0, 4'b0001);
    chk("t1_start", inv_start0, 1);
    chk("t1_inv_in", inv_in0, 8'h53);
    chk("t1_busy", busy0, 1);
    req0 = 0;
    repeat (7) tick();
    chk("t1_early", res_valid0, 0);
    tick();
    chk("t1_valid", res_valid0, 1);
    chk("t1_id", res_id0, 0);
    chk("t1_data", res_data0, 8'hCA);
    chk("t1_zero", res_zero0, 0);
    tick();
    chk("t1_pulse", res_valid0, 0);
    chk("t1_idle", busy0, 0);
    chk("t1_hold", inv_in0, 8'h53);
    tick();
    // zero operand bypasses the inverter
    data0 = 32'h0; req0 = 4'b0001;
    tick();
    chk("z_ack", ack0, 4'b0001);
    chk("z_start", inv_start0, 0);
    req0 = 0;
    tick();
    chk("z_valid", res_valid0, 1);
    chk("z_data", res_data0, 0);
    chk("z_zero", res_zero0, 1);
    chk("z_ack_off", ack0, 0);
    tick(); tick();
    // all four requesting continuously after a reset
    reset = 1; tick(); reset = 0;
    data0 = 32'h091F_8002; req0 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = 2'(k % 4);
      wait_ack("rr_ack", 4'b0001 << e);
      chk("rr_start", inv_start0, 1);
      if (k > 0) chk("rr_gap", cyc - last, 11);
      last = cyc;
      wait_valid("rr", e, gf_inv(data0[e*8 +: 8]));
    end
    req0 = 0;
    repeat (3) tick();
    // grant 2, then 0 and 2 together: pointer wraps past 3 to 0
    req0 = 4'b0100;
    wait_ack("w_ack2", 4'b0100);
    req0 = 0;
    wait_valid("w2", 2, gf_inv(8'h1F));
    req0 = 4'b0101;
    wait_ack("w_ack0", 4'b0001);
    req0 = 4'b0100;
    wait_valid("w0", 0, gf_inv(8'h02));
    wait_ack("w_ack2b", 4'b0100);
    req0 = 0;
    wait_valid("w2b", 2, gf_inv(8'h1F));
    repeat (3) tick();
    // reset in the middle of a running operation
    req0 = 4'b0010;
    tick();
    chk("mr_ack", ack0, 4'b0010);
    req0 = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    chk("mr_busy", busy0, 0);
    chk("mr_valid", res_valid0, 0);
    reset = 0;
    repeat (12) begin tick(); seen += int'(res_valid0); end
    chk("mr_no_result", seen, 0);
    req0 = 4'b0010;
    tick();
    chk("mr2_ack", ack0, 4'b0010);
    chk("mr2_start", inv_start0, 1);
    req0 = 0;
    wait_valid("mr2", 1, gf_inv(8'h80));
    // LATENCY=1 build, requester 3
    data1 = 32'h0100_0000; req1 = 4'b1000;
    tick();
    chk("l1_ack", ack1, 4'b1000);
    chk("l1_start", inv_start1, 1);
    req1 = 0;
    tick();
    chk("l1_valid", res_valid1, 1);
    chk("l1_id", res_id1, 3);
    chk("l1_data", res_data1, 8'h01);
    chk("l1_zero", res_zero1, 0);
    tick();
    chk("l1_pulse", res_valid1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
